riscy_mem: RTL and testbench

//  Unified instruction/data memory for the riscy core: one word array shared by an

---
 rtl/riscy_mem_pkg.sv | 34 +++
 rtl/riscy_mem_port_ctl.sv | 44 ++++
 rtl/riscy_mem.sv | 145 ++++++++++++++
 tb/tb_riscy_mem.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscy_mem_pkg.sv
// Shared constants, port FSM state type and load-extension helper for riscy_mem.
// Access sizes follow the d_size encoding.
package riscy_mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic {StIdle, StBusy} port_state_e;

   // Select the addressed byte/half of a stored word, move it to bit 0, then extend it.
   function automatic logic [31:0] load_extend(logic [31:0] word, logic [1:0] size,
                                                logic [1:0] off, logic sext);
      logic [31:0] sh;
      logic [31:0] res;
      sh  = '0;
      res = '0;
      unique case (size)
         SZ_BYTE: begin
            sh  = word >> {off, 3'b000};
            res = {{24{sext & sh[7]}}, sh[7:0]};
         end
         SZ_HALF: begin
            sh  = word >> {off[1], 4'b0000};
            res = {{16{sext & sh[15]}}, sh[15:0]};
         end
         SZ_WORD: res = word;
         SZ_RSVD: res = '0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/riscy_mem_port_ctl.sv
// Request/ack controller for one memory port: accepts a request, counts out LAT cycles,
// then strobes completion; ack is the registered completion strobe.
module riscy_mem_port_ctl
   import riscy_mem_pkg::*;
#(
   parameter int unsigned LAT = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req,
   output logic capture,
   output logic complete,
   output logic ack
);

   localparam int unsigned CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

   port_state_e      state_q;
   logic [CNT_W-1:0] cnt_q;

   assign complete = (state_q == StBusy) && (cnt_q == '0);
   // Accepting in the completion cycle lets LAT=1 sustain one access per cycle.
   assign capture  = req && ((state_q == StIdle) || complete);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         ack     <= 1'b0;
      end else begin
         ack <= complete;
         if (capture) begin
            state_q <= StBusy;
            cnt_q   <= CNT_LOAD;
         end else if (complete) begin
            state_q <= StIdle;
         end else if (state_q == StBusy) begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

endmodule

// File: rtl/riscy_mem.sv
// Unified instruction/data memory: aligned fetch port plus a byte/half/word data port,
// each with its own programmable wait-state latency.
module riscy_mem
   import riscy_mem_pkg::*;
#(
   parameter int unsigned ADDR_W    = 14,
   parameter int unsigned I_LAT     = 1,
   parameter int unsigned D_LAT     = 1,
   parameter string       INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [31:0]       i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [1:0]        d_size,
   input  logic              d_sext,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_ack,
   output logic [31:0]       d_rdata,
   output logic              d_misalign
);

   localparam int unsigned WORDS = 2 ** (ADDR_W - 2);

   logic [31:0] mem [WORDS];

   // The array is deliberately outside the reset domain.
   initial begin
      for (int w = 0; w < int'(WORDS); w++) mem[w] = '0;
   end

   logic i_capture, i_complete;
   logic d_capture, d_complete;

   riscy_mem_port_ctl #(.LAT(I_LAT)) u_i_ctl (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (i_req),
      .capture  (i_capture),
      .complete (i_complete),
      .ack      (i_ack)
   );

   riscy_mem_port_ctl #(.LAT(D_LAT)) u_d_ctl (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (d_req),
      .capture  (d_capture),
      .complete (d_complete),
      .ack      (d_ack)
   );

   logic              unused_i_addr;
   assign unused_i_addr = ^i_addr[1:0];

   logic [ADDR_W-3:0] i_idx_q;
   logic [ADDR_W-1:0] d_addr_q;
   logic              d_we_q;
   logic [1:0]        d_size_q;
   logic              d_sext_q;
   logic [31:0]       d_wdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_idx_q   <= '0;
         d_addr_q  <= '0;
         d_we_q    <= 1'b0;
         d_size_q  <= SZ_BYTE;
         d_sext_q  <= 1'b0;
         d_wdata_q <= '0;
      end else begin
         if (i_capture) i_idx_q <= i_addr[ADDR_W-1:2];
         if (d_capture) begin
            d_addr_q  <= d_addr;
            d_we_q    <= d_we;
            d_size_q  <= d_size;
            d_sext_q  <= d_sext;
            d_wdata_q <= d_wdata;
         end
      end
   end

   logic [ADDR_W-3:0] d_idx;
   logic              d_bad;
   logic [3:0]        d_be;
   logic [31:0]       d_lanes;

   assign d_idx = d_addr_q[ADDR_W-1:2];

   always_comb begin
      d_bad   = 1'b1;
      d_be    = 4'b0000;
      d_lanes = d_wdata_q;
      unique case (d_size_q)
         SZ_BYTE: begin
            d_bad   = 1'b0;
            d_be    = 4'b0001 << d_addr_q[1:0];
            d_lanes = {4{d_wdata_q[7:0]}};
         end
         SZ_HALF: begin
            d_bad   = d_addr_q[0];
            d_be    = d_addr_q[1] ? 4'b1100 : 4'b0011;
            d_lanes = {2{d_wdata_q[15:0]}};
         end
         SZ_WORD: begin
            d_bad = |d_addr_q[1:0];
            d_be  = 4'b1111;
         end
         SZ_RSVD: d_bad = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (d_complete && d_we_q && !d_bad) begin
         for (int i = 0; i < 4; i++) begin
            if (d_be[i]) mem[d_idx][8*i +: 8] <= d_lanes[8*i +: 8];
         end
      end
   end

   // Fetch reads with the same edge as a store, so a colliding fetch sees pre-store data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_rdata    <= '0;
         d_rdata    <= '0;
         d_misalign <= 1'b0;
      end else begin
         d_misalign <= d_complete && d_bad;
         if (i_complete) i_rdata <= mem[i_idx_q];
         if (d_complete) begin
            if (d_bad) begin
               d_rdata <= '0;
            end else if (!d_we_q) begin
               d_rdata <= load_extend(mem[d_idx], d_size_q, d_addr_q[1:0], d_sext_q);
            end
         end
      end
   end

endmodule

// File: tb/tb_riscy_mem.sv
// Bench for riscy_mem: instance 0 uses unit latency, instance 1 uses I_LAT=2/D_LAT=3.
// A byte-addressed model supplies expected load data and misalignment.
module tb_riscy_mem;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_req [2];
   logic [13:0] i_addr [2];
   logic        i_ack [2];
   logic [31:0] i_rdata [2];
   logic        d_req [2];
   logic        d_we [2];
   logic [1:0]  d_size [2];
   logic        d_sext [2];
   logic [13:0] d_addr [2];
   logic [31:0] d_wdata [2];
   logic        d_ack [2];
   logic [31:0] d_rdata [2];
   logic        d_misalign [2];

   int errors = 0;
   int checks = 0;
   logic [7:0] mb [2][16384];

   always #5 clk = ~clk;

   riscy_mem u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req[0]), .i_addr(i_addr[0]), .i_ack(i_ack[0]), .i_rdata(i_rdata[0]),
      .d_req(d_req[0]), .d_we(d_we[0]), .d_size(d_size[0]), .d_sext(d_sext[0]),
      .d_addr(d_addr[0]), .d_wdata(d_wdata[0]), .d_ack(d_ack[0]), .d_rdata(d_rdata[0]),
      .d_misalign(d_misalign[0])
   );

   riscy_mem #(.I_LAT(2), .D_LAT(3)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req[1]), .i_addr(i_addr[1]), .i_ack(i_ack[1]), .i_rdata(i_rdata[1]),
      .d_req(d_req[1]), .d_we(d_we[1]), .d_size(d_size[1]), .d_sext(d_sext[1]),
      .d_addr(d_addr[1]), .d_wdata(d_wdata[1]), .d_ack(d_ack[1]), .d_rdata(d_rdata[1]),
      .d_misalign(d_misalign[1])
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic bit m_mis(input int size, input int a);
      int n;
      n = 1 << size;
      return (size == 3) || ((a % n) != 0);
   endfunction

   function automatic logic [31:0] m_load(input int s, input int a, input int size,
                                          input bit sext);
      int n;
      logic [31:0] v;
      n = 1 << size;
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(mb[s][(a + i) % 16384]) << (8 * i));
      if (sext && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      return v;
   endfunction

   task automatic d_op(input int s, input bit we, input int size, input bit sext,
                       input int addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic mis, output int lat);
      bit got;
      @(negedge clk);
      d_req[s] = 1'b1; d_we[s] = we; d_size[s] = size[1:0]; d_sext[s] = sext;
      d_addr[s] = addr[13:0]; d_wdata[s] = wdata;
      @(posedge clk);
      #1 d_req[s] = 1'b0;
      lat = 0;
      got = 1'b0;
      while (lat < 20 && !got) begin
         @(posedge clk);
         #1 lat++;
         got = d_ack[s];
      end
      chk("d_ack_seen", 32'(got), 32'd1);
      rd  = d_rdata[s];
      mis = d_misalign[s];
   endtask

   task automatic fetch(input int s, input int addr, output logic [31:0] rd, output int lat);
      bit got;
      @(negedge clk);
      i_req[s] = 1'b1; i_addr[s] = addr[13:0];
      @(posedge clk);
      #1 i_req[s] = 1'b0;
      lat = 0;
      got = 1'b0;
      while (lat < 20 && !got) begin
         @(posedge clk);
         #1 lat++;
         got = i_ack[s];
      end
      chk("i_ack_seen", 32'(got), 32'd1);
      rd = i_rdata[s];
   endtask

   // Store through the DUT; the model commits only accesses that are legal.
   task automatic store(input int s, input int size, input int addr, input logic [31:0] wdata);
      logic [31:0] rd;
      logic mis;
      int lat;
      bit emis;
      emis = m_mis(size, addr);
      d_op(s, 1'b1, size, 1'b0, addr, wdata, rd, mis, lat);
      chk("store_misalign", 32'(mis), 32'(emis));
      if (!emis) for (int i = 0; i < (1 << size); i++) mb[s][addr + i] = wdata[8*i +: 8];
   endtask

   task automatic load(input int s, input int size, input bit sext, input int addr,
                       output logic [31:0] rd);
      logic mis;
      int lat;
      bit emis;
      emis = m_mis(size, addr);
      d_op(s, 1'b0, size, sext, addr, 32'h0, rd, mis, lat);
      chk("load_misalign", 32'(mis), 32'(emis));
      chk("load_model", rd, emis ? 32'h0 : m_load(s, addr, size, sext));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] rd;
      logic mis;
      int lat;
      int seen;
      for (int s = 0; s < 2; s++) begin
         for (int a = 0; a < 16384; a++) mb[s][a] = 8'h00;
         i_req[s] = 1'b0; i_addr[s] = '0; d_req[s] = 1'b0; d_we[s] = 1'b0;
         d_size[s] = 2'b10; d_sext[s] = 1'b0; d_addr[s] = '0; d_wdata[s] = '0;
      end

      // Reset held with requests pending.
      i_req[0] = 1'b1; d_req[0] = 1'b1;
      #22;
      chk("rst_i_ack", 32'(i_ack[0]), 32'd0);
      chk("rst_d_ack", 32'(d_ack[0]), 32'd0);
      chk("rst_i_rdata", i_rdata[0], 32'h0);
      chk("rst_d_rdata", d_rdata[0], 32'h0);
      chk("rst_d_misalign", 32'(d_misalign[0]), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1 i_req[0] = 1'b0; d_req[0] = 1'b0;
      chk("accept_no_ack", 32'(d_ack[0]), 32'd0);
      @(posedge clk);
      #1;
      chk("first_i_ack", 32'(i_ack[0]), 32'd1);
      chk("first_d_ack", 32'(d_ack[0]), 32'd1);
      @(posedge clk);
      #1;
      chk("ack_pulse", 32'(d_ack[0]), 32'd0);

      // Lane-merged stores and extended loads.
      store(0, 2, 'h10, 32'hDEADBEEF);
      store(0, 0, 'h13, 32'hAAAA557F);
      store(0, 1, 'h14, 32'h12348001);
      load(0, 2, 1'b0, 'h10, rd);  chk("word_merge", rd, 32'h7FADBEEF);
      load(0, 1, 1'b1, 'h14, rd);  chk("half_sext", rd, 32'hFFFF8001);
      load(0, 1, 1'b0, 'h14, rd);  chk("half_zext", rd, 32'h00008001);
      load(0, 0, 1'b1, 'h11, rd);  chk("byte_sext", rd, 32'hFFFFFFBE);
      load(0, 0, 1'b0, 'h11, rd);  chk("byte_zext", rd, 32'h000000BE);

      // Rejected accesses leave memory alone.
      store(0, 2, 'h20, 32'h12345678);
      store(0, 1, 'h21, 32'hFFFFFFFF);
      store(0, 2, 'h22, 32'hFFFFFFFF);
      store(0, 3, 'h20, 32'hFFFFFFFF);
      load(0, 1, 1'b0, 'h23, rd);  chk("misalign_rdata", rd, 32'h0);
      load(0, 2, 1'b0, 'h20, rd);  chk("misalign_nowrite", rd, 32'h12345678);

      // Latency on the slow instance.
      d_op(1, 1'b1, 2, 1'b0, 'h30, 32'h11112222, rd, mis, lat);
      for (int i = 0; i < 4; i++) mb[1]['h30 + i] = 8'(32'h11112222 >> (8 * i));
      chk("d_lat3", 32'(lat), 32'd3);
      fetch(1, 'h31, rd, lat);
      chk("i_lat2", 32'(lat), 32'd2);
      chk("i_lat2_data", rd, 32'h11112222);

      // Request held high: one ack every D_LAT cycles.
      @(negedge clk);
      d_req[1] = 1'b1; d_we[1] = 1'b0; d_size[1] = 2'b10; d_addr[1] = 14'h30;
      @(posedge clk);
      for (int e = 1; e <= 12; e++) begin
         @(posedge clk);
         #1 chk("held_ack_pattern", 32'(d_ack[1]), 32'((e % 3) == 0));
      end
      d_req[1] = 1'b0;
      repeat (5) @(posedge clk);

      // Reset while a store is in flight drops it.
      @(negedge clk);
      d_req[1] = 1'b1; d_we[1] = 1'b1; d_size[1] = 2'b10; d_addr[1] = 14'h30;
      d_wdata[1] = 32'hAAAA5555;
      @(posedge clk);
      #1 d_req[1] = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b0;
      seen = 0;
      repeat (3) begin
         @(posedge clk);
         #1 seen += int'(d_ack[1]);
      end
      @(negedge clk) rst_n = 1'b1;
      repeat (4) begin
         @(posedge clk);
         #1 seen += int'(d_ack[1]);
      end
      chk("rst_busy_no_ack", 32'(seen), 32'd0);
      load(1, 2, 1'b0, 'h30, rd);  chk("rst_busy_nowrite", rd, 32'h11112222);

      // Fetch and store complete on the same word in the same cycle.
      store(0, 2, 'h40, 32'h55667788);
      @(negedge clk);
      i_req[0] = 1'b1; i_addr[0] = 14'h40;
      d_req[0] = 1'b1; d_we[0] = 1'b1; d_size[0] = 2'b10; d_addr[0] = 14'h40;
      d_wdata[0] = 32'hCAFEF00D;
      @(posedge clk);
      #1 i_req[0] = 1'b0; d_req[0] = 1'b0;
      @(posedge clk);
      #1;
      chk("collide_i_ack", 32'(i_ack[0]), 32'd1);
      chk("collide_d_ack", 32'(d_ack[0]), 32'd1);
      chk("collide_old_data", i_rdata[0], 32'h55667788);
      for (int i = 0; i < 4; i++) mb[0]['h40 + i] = 8'(32'hCAFEF00D >> (8 * i));
      fetch(0, 'h40, rd, lat);
      chk("fetch_new_data", rd, 32'hCAFEF00D);

      // Random traffic against the model.
      for (int k = 0; k < 100; k++) begin
         int s, size, addr;
         s    = (k < 80) ? 0 : 1;
         size = $urandom_range(0, 3);
         addr = 'h100 + $urandom_range(0, 63);
         if ($urandom_range(0, 1) == 1) store(s, size, addr, $urandom);
         else load(s, size, 1'($urandom_range(0, 1)), addr, rd);
      end
      for (int w = 0; w < 16; w++) begin
         fetch(0, 'h100 + 4 * w + int'($urandom_range(0, 3)), rd, lat);
         chk("rand_fetch", rd, m_load(0, 'h100 + 4 * w, 2, 1'b0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
